// File: rtl/tonegen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tonegen_pkg
// Description : Shared constants and channel-index helpers for the tone
//               generator divider bank and waveform generators.
// Revision    : 1.0 - initial release
// ============================================================================
package tonegen_pkg;

    localparam int TONEGEN_MAX_CHANNELS = 16;
    localparam int TONEGEN_DIV_WIDTH    = 12;

    typedef logic [$clog2(TONEGEN_MAX_CHANNELS)-1:0] ch_idx_t;

    // Channel-select width; a single-channel bank still needs a 1-bit field.
    function automatic int ch_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tonegen_div_channel.sv
`default_nettype none
// ============================================================================
// Module      : tonegen_div_channel
// Description : One divider channel with double-buffered divisor, square-wave
//               output and per-toggle tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tonegen_div_channel
    import tonegen_pkg::*;
#(
    parameter int WIDTH = TONEGEN_DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_en,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_div_pend;
    logic [WIDTH-1:0] r_div_act;
    logic [WIDTH-1:0] r_cnt;
    logic             r_clk_out;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_pend <= '0;
            r_div_act  <= '0;
            r_cnt      <= '0;
            r_clk_out  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (i_wr) begin
                r_div_pend <= i_wr_data;
            end
            // div_act only changes with cnt at zero, so the output never runts.
            if (i_sync || !i_en) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                r_div_act <= r_div_pend;
            end else if (r_cnt >= r_div_act) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= 1'b1;
                r_div_act <= r_div_pend;
            end else begin
                r_cnt  <= r_cnt + WIDTH'(1);
                r_tick <= 1'b0;
            end
        end
    end

    assign o_clk  = r_clk_out;
    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/tonegen_clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module      : tonegen_clock_divider_bank
// Description : Bank of CHANNELS independent clock dividers with write-address
//               decode. Optional phase realign input under TONEGEN_DIV_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tonegen_clock_divider_bank
    import tonegen_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = TONEGEN_DIV_WIDTH,
    localparam int CH_W     = ch_idx_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef TONEGEN_DIV_SYNC_EN
    input  logic                sync,
`endif
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic w_sync;

`ifdef TONEGEN_DIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range wr_ch matches no channel, so the write is dropped.
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
            logic w_wr_sel;
            assign w_wr_sel = wr_en && (wr_ch == CH_W'(i));

            tonegen_div_channel #(
                .WIDTH (WIDTH)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .i_wr      (w_wr_sel),
                .i_wr_data (wr_data),
                .i_en      (ch_en[i]),
                .i_sync    (w_sync),
                .o_clk     (clk_out[i]),
                .o_tick    (tick[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tonegen_clock_divider_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_tonegen_clock_divider_bank
// Description : Self-checking bench: vector table, corner sequences and
//               randomized run against a countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tonegen_clock_divider_bank;

    localparam int NCH = 3;
    localparam int W   = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sync = 1'b0;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [W-1:0]   wr_data = '0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int checks = 0;
    int errors = 0;

    // Reference model: edges remaining until the next toggle of each channel.
    int       m_pend [NCH];
    int       m_rem  [NCH];
    bit [NCH-1:0] m_clk;
    bit [NCH-1:0] m_tick;

    tonegen_clock_divider_bank #(
        .CHANNELS (NCH),
        .WIDTH    (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef TONEGEN_DIV_SYNC_EN
        .sync    (sync),
`endif
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_data (wr_data),
        .ch_en   (ch_en),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic           we;
        logic [1:0]     wc;
        logic [W-1:0]   wd;
        logic [NCH-1:0] en;
        logic [NCH-1:0] eclk;
        logic [NCH-1:0] etick;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic r, input logic we, input logic [1:0] wc,
                                input int wd, input logic [NCH-1:0] en,
                                input logic [NCH-1:0] ec, input logic [NCH-1:0] et);
        vec_t v;
        v.rst = r; v.we = we; v.wc = wc; v.wd = W'(wd); v.en = en; v.eclk = ec; v.etick = et;
        return v;
    endfunction

    task automatic model_step();
        bit sy;
`ifdef TONEGEN_DIV_SYNC_EN
        sy = sync;
`else
        sy = 1'b0;
`endif
        for (int i = 0; i < NCH; i++) begin
            int old_pend;
            if (rst) begin
                m_pend[i] = 0; m_rem[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
            end else begin
                old_pend = m_pend[i];
                if (wr_en && int'(wr_ch) == i) m_pend[i] = int'(wr_data);
                if (sy || !ch_en[i]) begin
                    m_rem[i] = old_pend; m_clk[i] = 0; m_tick[i] = 0;
                end else if (m_rem[i] == 0) begin
                    m_rem[i] = old_pend; m_clk[i] = ~m_clk[i]; m_tick[i] = 1;
                end else begin
                    m_rem[i] = m_rem[i] - 1; m_tick[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [1:0] wc,
                        input logic [W-1:0] wd, input logic [NCH-1:0] en, input logic sy);
        rst = r; wr_en = we; wr_ch = wc; wr_data = wd; ch_en = en; sync = sy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        tbl[1]  = mk(0, 1, 0, 3, 3'b000, 3'b000, 3'b000);
        tbl[2]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        tbl[3]  = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        tbl[4]  = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        tbl[5]  = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        tbl[6]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b001);
        tbl[7]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
        tbl[8]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
        tbl[9]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
        tbl[10] = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b001);
        tbl[11] = mk(0, 1, 3, 7, 3'b001, 3'b000, 3'b000);
        tbl[12] = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        tbl[13] = mk(0, 0, 0, 0, 3'b111, 3'b110, 3'b110);
        tbl[14] = mk(0, 0, 0, 0, 3'b111, 3'b001, 3'b111);
        tbl[15] = mk(0, 0, 0, 0, 3'b111, 3'b111, 3'b110);
        tbl[16] = mk(1, 0, 0, 0, 3'b111, 3'b000, 3'b000);
        tbl[17] = mk(0, 0, 0, 0, 3'b111, 3'b111, 3'b111);
        tbl[18] = mk(0, 0, 0, 0, 3'b111, 3'b000, 3'b111);

        for (int k = 0; k < 19; k++) begin
            step(tbl[k].rst, tbl[k].we, tbl[k].wc, tbl[k].wd, tbl[k].en, 1'b0);
            check($sformatf("tbl%0d_clk", k), clk_out, tbl[k].eclk);
            check($sformatf("tbl%0d_tick", k), tick, tbl[k].etick);
        end

        // Divisor rewrite on the exact wrap edge: one more 6-cycle half, then 2.
        step(1, 0, 0, 0, 3'b000, 0);
        step(0, 1, 1, 5, 3'b000, 0);
        step(0, 0, 0, 0, 3'b000, 0);
        for (int k = 0; k <= 16; k++) begin
            logic et, ec;
            step(0, (k == 5), 2'd1, W'(1), 3'b010, 0);
            et = (k == 5) || (k == 11) || (k == 13) || (k == 15);
            ec = (k >= 5 && k <= 10) || (k == 13) || (k == 14);
            check($sformatf("upd%0d_tick", k), tick, {1'b0, et, 1'b0});
            check($sformatf("upd%0d_clk", k), clk_out, {1'b0, ec, 1'b0});
        end

        // Disable latency: outputs clear after the first disabled edge.
        step(0, 0, 0, 0, 3'b000, 0);
        check("dis_clk", clk_out, 3'b000);
        check("dis_tick", tick, 3'b000);

`ifdef TONEGEN_DIV_SYNC_EN
        step(1, 0, 0, 0, 3'b000, 0);
        step(0, 1, 0, 2, 3'b000, 0);
        step(0, 1, 1, 2, 3'b000, 0);
        step(0, 0, 0, 0, 3'b000, 0);
        step(0, 0, 0, 0, 3'b001, 0);
        step(0, 0, 0, 0, 3'b001, 0);
        step(0, 0, 0, 0, 3'b011, 0);
        step(0, 0, 0, 0, 3'b011, 1);
        check("sync_clk", clk_out, 3'b000);
        check("sync_tick", tick, 3'b000);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 3'b011, 0);
            check($sformatf("sync%0d_tick", k), tick, (k == 3) ? 3'b011 : 3'b000);
            check($sformatf("sync%0d_clk", k), clk_out, (k == 3) ? 3'b011 : 3'b000);
        end
`endif

        // Randomized run against the reference model.
        step(1, 0, 0, 0, 3'b000, 0);
        for (int k = 0; k < 2000; k++) begin
            logic [NCH-1:0] en;
            logic           sy;
            for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(7) != 0);
`ifdef TONEGEN_DIV_SYNC_EN
            sy = ($urandom_range(31) == 0);
`else
            sy = 1'b0;
`endif
            step(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                 2'($urandom_range(3)), W'($urandom_range(7)), en, sy);
            check("rnd_clk", clk_out, m_clk);
            check("rnd_tick", tick, m_tick);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tonegen_clock_divider_bank.md
# tonegen_clock_divider_bank

Multi-channel, parametrised clock divider bank for the tone generator. Each channel turns the system clock into a square-wave tone clock with a programmable half-period, and adds a single-cycle wrap tick. Divisor updates are glitch-free: they are double-buffered and applied only at a wrap or while the channel is disabled. The bank sits between the register interface and the per-voice waveform generators, replacing the single fixed-width scaler.

## Interface
Parameters:
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 12, divisor and counter width in bits (2..24)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  divisor write strobe; a write is accepted in every cycle it is high
- wr_ch  in  CH_W  target channel, where CH_W = max(1, $clog2(CHANNELS))
- wr_data  in  WIDTH  new divisor D
- ch_en  in  CHANNELS  per-channel run enable
- clk_out  out  CHANNELS  per-channel divided clock, registered
- tick  out  CHANNELS  one-cycle pulse on each clk_out toggle, registered
- sync  in  1  phase realign; present only with TONEGEN_DIV_SYNC_EN

## Operation
- Per-channel state:
  - div_pend: shadow register, the target of writes
  - div_act: the divisor in use
  - cnt: WIDTH-bit counter
  - clk_out and tick
- Reset: div_pend, div_act, cnt, clk_out and tick are all 0 on every channel.
- Write: when wr_en is high and wr_ch < CHANNELS, div_pend[wr_ch] <= wr_data. When wr_ch >= CHANNELS, the write is silently dropped.
- Channel disabled (ch_en[i] = 0):
  - cnt <= 0, clk_out <= 0, tick <= 0
  - div_act <= div_pend, i.e. a pending value is loaded immediately
- Channel enabled, cnt >= div_act (wrap):
  - cnt <= 0
  - clk_out toggles
  - tick <= 1
  - div_act <= div_pend
- Channel enabled, otherwise:
  - cnt <= cnt + 1
  - tick <= 0
- Output period is 2·(D+1) clk cycles at a 50 % duty cycle. D = 0 toggles on every enabled edge (period 2).
- The comparison is >=, not ==. If div_act ever falls below cnt, the next edge wraps, so there is no 2^WIDTH runaway.
- Write and wrap on the same channel in the same edge: the wrap loads the old div_pend, and the newly written value takes effect at the following wrap.
- Write to a disabled channel in cycle t: div_act holds the new value after edge t+1.
- Channels are fully independent. A write to one channel never disturbs the cnt or clk_out of any other channel.

## Timing
- No combinational paths from inputs to outputs.
- Enable latency: ch_en[i] rises before edge e with cnt = 0, so the first toggle and tick occur on edge e + D. clk_out is visible high after that edge.
- Disable latency: clk_out and tick are 0 after the first edge sampled with ch_en = 0.
- Reset mid-operation: the next edge clears all state, including div_pend. rst has priority over wr_en, sync and ch_en.
- tick is high for exactly one cycle per toggle. Steady state gives D cycles low between ticks. With D = 0, tick stays continuously high.

## Configuration
- TONEGEN_DIV_SYNC_EN defined:
  - The sync port exists. Priority order is below rst and above normal counting.
  - An edge with sync = 1 sets, on every channel: cnt <= 0, clk_out <= 0, tick <= 0, div_act <= div_pend.
  - Writes in the same cycle still update div_pend.
  - Enabled channels restart in phase.
- TONEGEN_DIV_SYNC_EN undefined: no sync port and no sync logic. The behaviour is identical to the defined case with sync tied to 0.

## Structure
- tonegen_pkg holds:
  - TONEGEN_MAX_CHANNELS = 16
  - the ch_idx_t width helper
  - the default divisor width constant shared with the waveform generators
- Sub-module tonegen_div_channel holds one channel's div_pend, div_act, cnt, clk_out and tick. Its inputs are a decoded write strobe, wr_data, ch_en and sync.
- The top level instantiates tonegen_div_channel with a generate loop over CHANNELS and performs the write address decode.

## Test plan
- Reset then enable: write D = 3 to channel 0, enable it → clk_out[0] toggles every 4 cycles (period 8), tick[0] pulses once per toggle, and all other channels stay 0.
- D = 0 on channel 2 → clk_out[2] toggles on every cycle and tick[2] is held at 1.
- Mid-run update: channel 1 runs with D = 5; write D = 1 on the exact wrap edge → one more half-period of 6 cycles, then half-periods of 2, with no runt pulse.
- Out-of-range write: with CHANNELS = 3, write wr_ch = 3 with data 7 → no div_pend changes on any channel.
- Reset mid-operation: assert rst for 1 cycle while channels toggle → all outputs 0 the next cycle, and after re-enable D = 0 behaviour applies.
- With TONEGEN_DIV_SYNC_EN: channels 0 and 1 run with D = 2 at different phases; pulse sync → both restart and toggle simultaneously 3 edges later.
